// File: rtl/burst_ram_arbiter_pkg.sv
// rtl/burst_ram_arbiter_pkg.sv - shared types and constants for the BurstRAM arbiter
//
// Purpose : command encodings, FSM state type and client index type used by
//           the arbiter, its round-robin picker and the testbench.
package burst_ram_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WRITE_BURST,
      READ_WAIT
   } state_t;

   // Index of one of the two cache clients
   typedef logic client_t;

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// rtl/burst_ram_arbiter_if.sv - client and BurstRAM signal bundle for the arbiter
//
// Purpose : groups both client ports and the BurstRAM port into one bundle.
// Modports:
//   slave  - arbiter side: takes client requests and RAM status, drives
//            grants, read-valid routing and the RAM command/write port.
//   master - environment side (clients plus BurstRAM), the mirror image.
interface burst_ram_arbiter_if #(
   parameter int ADDR_BITWIDTH = 10,
   parameter int DATA_BITWIDTH = 64
) ();
   localparam int MASK_BITWIDTH = DATA_BITWIDTH / 8;

   // client 0
   logic                     c0_req;
   logic                     c0_cmd;
   logic [ADDR_BITWIDTH-1:0] c0_addr;
   logic [DATA_BITWIDTH-1:0] c0_wr_data;
   logic [MASK_BITWIDTH-1:0] c0_data_mask;
   logic                     c0_gnt;
   logic                     c0_rd_data_valid;
   // client 1
   logic                     c1_req;
   logic                     c1_cmd;
   logic [ADDR_BITWIDTH-1:0] c1_addr;
   logic [DATA_BITWIDTH-1:0] c1_wr_data;
   logic [MASK_BITWIDTH-1:0] c1_data_mask;
   logic                     c1_gnt;
   logic                     c1_rd_data_valid;
   // shared read data
   logic [DATA_BITWIDTH-1:0] rd_data;
   // BurstRAM port
   logic                     br_cmd;
   logic                     br_cmd_en;
   logic [ADDR_BITWIDTH-1:0] br_addr;
   logic [DATA_BITWIDTH-1:0] br_wr_data;
   logic [MASK_BITWIDTH-1:0] br_data_mask;
   logic [DATA_BITWIDTH-1:0] br_rd_data;
   logic                     br_rd_data_valid;
   logic                     br_init_calib;
   logic                     br_busy;

   modport slave (
      input  c0_req, c0_cmd, c0_addr, c0_wr_data, c0_data_mask,
      input  c1_req, c1_cmd, c1_addr, c1_wr_data, c1_data_mask,
      input  br_rd_data, br_rd_data_valid, br_init_calib, br_busy,
      output c0_gnt, c0_rd_data_valid, c1_gnt, c1_rd_data_valid, rd_data,
      output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );

   modport master (
      output c0_req, c0_cmd, c0_addr, c0_wr_data, c0_data_mask,
      output c1_req, c1_cmd, c1_addr, c1_wr_data, c1_data_mask,
      output br_rd_data, br_rd_data_valid, br_init_calib, br_busy,
      input  c0_gnt, c0_rd_data_valid, c1_gnt, c1_rd_data_valid, rd_data,
      input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );

endinterface

// File: rtl/burst_ram_arbiter_rr_arbiter_2.sv
// rtl/burst_ram_arbiter_rr_arbiter_2.sv - combinational 2-way round-robin pick
//
// Purpose : picks the client to serve from the raw request pair.
// Ports   : i_req[1:0] request per client, i_last last owner,
//           o_grant chosen client index, o_any_req any request present.
import burst_ram_pkg::*;

module rr_arbiter_2 (
   input  logic [1:0] i_req,
   input  client_t    i_last,
   output client_t    o_grant,
   output logic       o_any_req
);

   assign o_any_req = |i_req;
   // On a tie the client that did not own the RAM last wins; otherwise the
   // lone requester (index 1 only if client 1 is asking).
   assign o_grant   = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule

// File: rtl/burst_ram_arbiter.sv
// rtl/burst_ram_arbiter.sv - shares one BurstRAM port between two cache clients
//
// Purpose : round-robin grants whole bursts, issues the command, steers the
//           owner's write beats to the RAM and routes read beats to the owner.
// Ports   : clk, sys_rst_n (async active-low),
//           bus   - slave modport of burst_ram_arbiter_if (clients + BurstRAM),
//           owner - current or last owner, busy - arbiter not idle.
import burst_ram_pkg::*;

module burst_ram_arbiter #(
   parameter int ADDR_BITWIDTH = 10,
   parameter int DATA_BITWIDTH = 64,
   parameter int BURST_COUNT   = 4
) (
   input  logic                clk,
   input  logic                sys_rst_n,
   burst_ram_arbiter_if.slave  bus,
   output logic                owner,
   output logic                busy
);

   localparam int                BEAT_W    = $clog2(BURST_COUNT) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

   state_t                   r_state;
   client_t                  r_owner;
   logic [BEAT_W-1:0]        r_beat;
   logic                     r_cmd;
   logic [ADDR_BITWIDTH-1:0] r_addr;
   logic                     r_cmd_en;
   logic [1:0]               r_gnt;

   client_t                  w_pick;
   logic                     w_any_req;
   logic                     w_start;
   logic                     w_rd_route;

   rr_arbiter_2 u_rr (
      .i_req     ({bus.c1_req, bus.c0_req}),
      .i_last    (r_owner),
      .o_grant   (w_pick),
      .o_any_req (w_any_req)
   );

   // br_busy and calibration only gate the decision taken in IDLE
   assign w_start = (r_state == IDLE) && bus.br_init_calib && !bus.br_busy && w_any_req;

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state  <= IDLE;
         r_owner  <= 1'b1;   // so client 0 wins the first tie
         r_beat   <= '0;
         r_cmd    <= CMD_READ;
         r_addr   <= '0;
         r_cmd_en <= 1'b0;
         r_gnt    <= 2'b00;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_owner  <= w_pick;
                  r_cmd    <= w_pick ? bus.c1_cmd  : bus.c0_cmd;
                  r_addr   <= w_pick ? bus.c1_addr : bus.c0_addr;
                  r_cmd_en <= 1'b1;
                  r_gnt    <= w_pick ? 2'b10 : 2'b01;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               r_cmd_en <= 1'b0;
               r_gnt    <= 2'b00;
               if (r_cmd == CMD_WRITE) begin
                  // beat 0 went out alongside the command
                  r_beat  <= BEAT_W'(1);
                  r_state <= WRITE_BURST;
               end else begin
                  r_beat  <= '0;
                  r_state <= READ_WAIT;
               end
            end
            WRITE_BURST: begin
               if (r_beat == LAST_BEAT) begin
                  r_beat  <= '0;
                  r_state <= IDLE;
               end else begin
                  r_beat  <= r_beat + BEAT_W'(1);
               end
            end
            READ_WAIT: begin
               if (bus.br_rd_data_valid) begin
                  if (r_beat == LAST_BEAT) begin
                     r_beat  <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_beat  <= r_beat + BEAT_W'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.br_cmd       = r_cmd;
   assign bus.br_cmd_en    = r_cmd_en;
   assign bus.br_addr      = r_addr;
   assign bus.c0_gnt       = r_gnt[0];
   assign bus.c1_gnt       = r_gnt[1];

   // Write port always follows the owner so beats pass through with no added latency
   assign bus.br_wr_data   = r_owner ? bus.c1_wr_data   : bus.c0_wr_data;
   assign bus.br_data_mask = r_owner ? bus.c1_data_mask : bus.c0_data_mask;

   // Read beats are only meaningful while a read burst is outstanding
   assign w_rd_route           = (r_state == READ_WAIT) && bus.br_rd_data_valid;
   assign bus.c0_rd_data_valid = w_rd_route && !r_owner;
   assign bus.c1_rd_data_valid = w_rd_route &&  r_owner;
   assign bus.rd_data          = bus.br_rd_data;

   assign owner = r_owner;
   assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb/tb_burst_ram_arbiter.sv - scoreboard testbench for burst_ram_arbiter
import burst_ram_pkg::*;

module tb_burst_ram_arbiter;

   localparam int AW = 10;
   localparam int DW = 64;
   localparam int BC = 4;
   localparam int MW = DW / 8;
   localparam int NEVER = 32'h3fff_ffff;

   typedef struct packed {
      logic                   cmd;
      logic [AW-1:0]          addr;
      logic [MW-1:0]          mask;
      logic [BC-1:0][DW-1:0]  data;
   } req_t;

   logic clk = 1'b0;
   logic sys_rst_n;
   logic owner;
   logic busy;

   burst_ram_arbiter_if #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW)) bus ();

   burst_ram_arbiter #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [DW-1:0] ram  [1<<AW];   // contents as seen by the BurstRAM model
   logic [DW-1:0] gold [1<<AW];   // contents the clients intended to write

   req_t          cq0[$];
   req_t          cq1[$];
   logic [DW-1:0] rd_exp[$];

   int ram_stop = 0;
   int stray_n  = 0;

   bit      contend_chk = 0;
   int      last_issue  = -1;
   client_t last_win    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic req_t mk(input logic cmd, input logic [AW-1:0] addr);
      req_t r;
      r.cmd  = cmd;
      r.addr = addr;
      r.mask = MW'($urandom);
      for (int b = 0; b < BC; b++) r.data[b] = {$urandom, $urandom};
      return r;
   endfunction

   // ---------------- monitor + reference model ----------------
   initial begin : monitor
      int      exp_issue = -1;
      int      free_at   = 0;
      bit      rd_active = 0;
      bit      rd_arm    = 0;
      int      rd_left   = 0;
      client_t rd_owner  = 1'b0;
      client_t m_owner   = 1'b1;
      client_t exp_win   = 1'b0;
      int      wr_idx    = BC;
      req_t    cur       = '0;
      bit      is_issue;
      forever begin
         @(negedge clk);
         cyc++;
         if (!sys_rst_n) begin
            chk("rst_busy",  busy, 0);
            chk("rst_owner", owner, 1);
            chk("rst_cmd_en", bus.br_cmd_en, 0);
            chk("rst_gnt0", bus.c0_gnt, 0);
            chk("rst_gnt1", bus.c1_gnt, 0);
            chk("rst_rdv0", bus.c0_rd_data_valid, 0);
            chk("rst_rdv1", bus.c1_rd_data_valid, 0);
            exp_issue = -1; free_at = 0; rd_active = 0; rd_arm = 0;
            m_owner = 1'b1; wr_idx = BC; last_issue = -1;
            rd_exp.delete(); cq0.delete(); cq1.delete();
            continue;
         end
         is_issue = (cyc == exp_issue);
         chk("cmd_en", bus.br_cmd_en, is_issue);
         chk("gnt0", bus.c0_gnt, is_issue && exp_win == 1'b0);
         chk("gnt1", bus.c1_gnt, is_issue && exp_win == 1'b1);
         if (is_issue) begin
            if ((exp_win ? cq1.size() : cq0.size()) == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL issue_queue: got grant with no pending request for client %0d", exp_win);
            end else begin
               cur = exp_win ? cq1.pop_front() : cq0.pop_front();
               chk("br_addr", bus.br_addr, cur.addr);
               chk("br_cmd",  bus.br_cmd,  cur.cmd);
               if (contend_chk && last_issue >= 0) begin
                  chk("spacing", cyc - last_issue, BC + 1);
                  chk("alternate", exp_win, !last_win);
               end
               last_issue = cyc;
               last_win   = exp_win;
               if (cur.cmd == CMD_WRITE) begin
                  wr_idx  = 0;
                  free_at = cyc + BC;
                  for (int b = 0; b < BC; b++) gold[AW'(cur.addr + b)] = cur.data[b];
               end else begin
                  for (int b = 0; b < BC; b++) rd_exp.push_back(gold[AW'(cur.addr + b)]);
                  rd_owner = exp_win;
                  rd_left  = BC;
                  rd_arm   = 1;
               end
            end
         end
         if (wr_idx < BC) begin
            chk("wr_beat", bus.br_wr_data, cur.data[wr_idx]);
            chk("wr_mask", bus.br_data_mask, cur.mask);
            wr_idx++;
         end
         if (rd_active) begin
            chk("rdv_owner", rd_owner ? bus.c1_rd_data_valid : bus.c0_rd_data_valid, bus.br_rd_data_valid);
            chk("rdv_other", rd_owner ? bus.c0_rd_data_valid : bus.c1_rd_data_valid, 0);
            if (bus.br_rd_data_valid) begin
               if (rd_exp.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL rd_extra: got read beat %0h with none expected", bus.rd_data);
               end else begin
                  chk("rd_data", bus.rd_data, rd_exp.pop_front());
               end
               rd_left--;
               if (rd_left == 0) begin
                  rd_active = 0;
                  free_at   = cyc + 1;
               end
            end
         end else begin
            chk("rdv0_quiet", bus.c0_rd_data_valid, 0);
            chk("rdv1_quiet", bus.c1_rd_data_valid, 0);
         end
         if (rd_arm) begin
            rd_active = 1;
            rd_arm    = 0;
         end
         chk("busy",  busy,  cyc < free_at);
         chk("owner", owner, m_owner);
         if (cyc >= free_at && bus.br_init_calib && !bus.br_busy && (bus.c0_req || bus.c1_req)) begin
            exp_win   = (bus.c0_req && bus.c1_req) ? !m_owner : bus.c1_req;
            m_owner   = exp_win;
            exp_issue = cyc + 1;
            free_at   = NEVER;
         end
      end
   end

   // ---------------- BurstRAM model ----------------
   initial begin : ram_model
      logic [AW-1:0] a;
      int lat, nb;
      bus.br_rd_data_valid = 1'b0;
      bus.br_rd_data       = '0;
      forever begin
         @(negedge clk);
         if (stray_n > 0) begin
            @(posedge clk); #1;
            bus.br_rd_data_valid = 1'b1;
            bus.br_rd_data       = {$urandom, $urandom};
            @(posedge clk); #1;
            bus.br_rd_data_valid = 1'b0;
            stray_n--;
         end else if (sys_rst_n && bus.br_cmd_en) begin
            a = bus.br_addr;
            if (bus.br_cmd == CMD_WRITE) begin
               for (int b = 0; b < BC; b++) begin
                  ram[AW'(a + b)] = bus.br_wr_data;
                  if (b < BC - 1) @(negedge clk);
               end
            end else begin
               lat = $urandom_range(1, 6);
               nb  = (ram_stop > 0) ? ram_stop : BC;
               repeat (lat) begin @(posedge clk); #1; end
               for (int b = 0; b < nb; b++) begin
                  bus.br_rd_data_valid = 1'b1;
                  bus.br_rd_data       = ram[AW'(a + b)];
                  @(posedge clk); #1;
                  bus.br_rd_data_valid = 1'b0;
                  if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
               end
            end
         end
      end
   end

   // ---------------- client driver ----------------
   task automatic client_op(input int c, input req_t r, input bit keep);
      bit got = 0;
      int waited = 0;
      if (c == 0) begin
         bus.c0_cmd = r.cmd; bus.c0_addr = r.addr; bus.c0_wr_data = r.data[0];
         bus.c0_data_mask = r.mask; cq0.push_back(r); bus.c0_req = 1'b1;
      end else begin
         bus.c1_cmd = r.cmd; bus.c1_addr = r.addr; bus.c1_wr_data = r.data[0];
         bus.c1_data_mask = r.mask; cq1.push_back(r); bus.c1_req = 1'b1;
      end
      while (!got && waited < 300) begin
         @(negedge clk);
         got = (c == 0) ? bus.c0_gnt : bus.c1_gnt;
         waited++;
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL gnt_timeout: client %0d got no grant, required one within 300 cycles", c);
         if (c == 0) bus.c0_req = 1'b0; else bus.c1_req = 1'b0;
         return;
      end
      if (r.cmd == CMD_WRITE) begin
         for (int b = 1; b < BC; b++) begin
            @(posedge clk); #1;
            if (c == 0) bus.c0_wr_data = r.data[b]; else bus.c1_wr_data = r.data[b];
         end
      end
      @(posedge clk); #1;
      if (!keep) begin
         if (c == 0) bus.c0_req = 1'b0; else bus.c1_req = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((busy || bus.c0_req || bus.c1_req || bus.br_rd_data_valid) && k < 1000);
      if (k >= 1000) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: busy=%0b, required 0 within 1000 cycles", busy);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      req_t r;
      int   nv, k;
      for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; gold[i] = '0; end
      sys_rst_n = 1'b0;
      bus.br_init_calib = 1'b0; bus.br_busy = 1'b0;
      bus.c0_req = 1'b0; bus.c0_cmd = 1'b0; bus.c0_addr = '0; bus.c0_wr_data = '0; bus.c0_data_mask = '0;
      bus.c1_req = 1'b0; bus.c1_cmd = 1'b0; bus.c1_addr = '0; bus.c1_wr_data = '0; bus.c1_data_mask = '0;
      repeat (3) @(posedge clk);
      #1 sys_rst_n = 1'b1;

      // calibration gate
      fork
         client_op(0, mk(CMD_READ, 10'h010), 0);
         begin repeat (10) @(posedge clk); #1 bus.br_init_calib = 1'b1; end
      join
      wait_idle();

      // single write by client 1, read back by client 0
      r = mk(CMD_WRITE, 10'h020);
      r.data[0] = 64'h1111_1111_1111_1111;
      r.data[1] = 64'h2222_2222_2222_2222;
      r.data[2] = 64'h3333_3333_3333_3333;
      r.data[3] = 64'h4444_4444_4444_4444;
      client_op(1, r, 0);
      client_op(0, mk(CMD_READ, 10'h020), 0);
      wait_idle();

      // tie after reset
      sys_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 sys_rst_n = 1'b1;
      fork
         client_op(0, mk(CMD_READ, 10'h020), 0);
         client_op(1, mk(CMD_READ, 10'h024), 0);
      join
      wait_idle();

      // sustained write contention
      last_issue  = -1;
      contend_chk = 1;
      fork
         for (int i = 0; i < 8; i++) client_op(0, mk(CMD_WRITE, AW'($urandom_range(0, 15) * 4)), i < 7);
         for (int i = 0; i < 8; i++) client_op(1, mk(CMD_WRITE, AW'($urandom_range(0, 15) * 4)), i < 7);
      join
      wait_idle();
      contend_chk = 0;

      // randomized mix of reads and writes
      fork
         for (int i = 0; i < 6; i++) begin
            client_op(0, mk(CMD_WRITE ^ logic'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4)), 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         for (int i = 0; i < 6; i++) begin
            client_op(1, mk(CMD_WRITE ^ logic'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4)), 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      join
      wait_idle();

      // stray read-valid while idle
      stray_n = 3;
      k = 0;
      while (stray_n > 0 && k < 50) begin @(negedge clk); k++; end
      wait_idle();

      // br_busy holds the arbiter in IDLE
      bus.br_busy = 1'b1;
      fork
         client_op(1, mk(CMD_WRITE, 10'h040), 0);
         begin repeat (8) @(posedge clk); #1 bus.br_busy = 1'b0; end
      join
      wait_idle();

      // reset in the middle of a read burst
      ram_stop = 2;
      client_op(1, mk(CMD_READ, 10'h020), 0);
      nv = 0; k = 0;
      while (nv < 2 && k < 50) begin
         @(negedge clk);
         if (bus.br_rd_data_valid) nv++;
         k++;
      end
      chk("mid_beats_seen", nv, 2);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_owner", owner, 1);
      chk("mid_rst_cmd_en", bus.br_cmd_en, 0);
      chk("mid_rst_gnt", {bus.c0_gnt, bus.c1_gnt}, 0);
      chk("mid_rst_rdv", {bus.c0_rd_data_valid, bus.c1_rd_data_valid}, 0);
      ram_stop = 0;
      repeat (3) @(posedge clk);
      #1 sys_rst_n = 1'b1;
      client_op(1, mk(CMD_READ, 10'h020), 0);
      wait_idle();

      chk("leftover", cq0.size() + cq1.size() + rd_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within 500000 time units");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM port between two cache clients, for example an instruction cache on client 0 and a data cache on client 1.
- Each client raises a held request. The arbiter grants round-robin, issues the command, and steers write beats from the owner to the RAM.
- Read-valid beats are routed back to the owner only. Ownership is held until the whole burst completes.

Parameters:
- ADDR_BITWIDTH, 10: BurstRAM address width; address unit is one 64-bit word.
- DATA_BITWIDTH, 64: width of one burst beat.
- BURST_COUNT, 4: beats per read or write burst; must be ≥2.

Ports:
- clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- c0_req / c1_req  in  1  request; held high until gnt.
- c0_cmd / c1_cmd  in  1  0: read, 1: write; stable while req.
- c0_addr / c1_addr  in  ADDR_BITWIDTH  burst start address; stable while req.
- c0_wr_data / c1_wr_data  in  DATA_BITWIDTH  write beats.
- c0_data_mask / c1_data_mask  in  DATA_BITWIDTH/8  forwarded unchanged.
- c0_gnt / c1_gnt  out  1  one-cycle pulse; the command issues this cycle.
- c0_rd_data_valid / c1_rd_data_valid  out  1  read beat valid for this client.
- rd_data  out  DATA_BITWIDTH  br_rd_data broadcast to both clients.
- br_cmd, br_cmd_en  out  1  to BurstRAM.
- br_addr  out  ADDR_BITWIDTH  to BurstRAM.
- br_wr_data  out  DATA_BITWIDTH  to BurstRAM.
- br_data_mask  out  DATA_BITWIDTH/8  to BurstRAM.
- br_rd_data  in  DATA_BITWIDTH  from BurstRAM.
- br_rd_data_valid, br_init_calib, br_busy  in  1  from BurstRAM.
- owner  out  1  current or last owner.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset values:
  - state=IDLE, owner=1 (so client 0 wins the first tie), beat counter=0.
  - All gnt, br_cmd_en and rd_data_valid outputs are 0; busy=0.
- States: IDLE, ISSUE, WRITE_BURST, READ_WAIT.
- IDLE:
  - Leaves only when br_init_calib=1, br_busy=0 and some req=1.
  - Winner selection: the only requester, or on a tie the client != owner.
  - Registers the winner into owner and latches cmd/addr. Next state is ISSUE.
- ISSUE (one cycle):
  - Drives br_cmd_en=1 with the latched br_cmd and br_addr; the winner's gnt=1.
  - Timing: br_cmd_en and gnt rise exactly 1 cycle after the qualifying IDLE cycle.
  - Write: br_wr_data and br_data_mask equal owner wr_data/data_mask combinationally (beat 0). Next state is WRITE_BURST with beat=1.
  - Read: next state is READ_WAIT with beat=0.
- WRITE_BURST:
  - Owner wr_data is forwarded each cycle as beats 1..BURST_COUNT-1, one per cycle, with no stalls.
  - The client must present beat 0 while req is high and the next beat each cycle after gnt.
  - After the beat BURST_COUNT-1 cycle, return to IDLE.
- READ_WAIT:
  - c{owner}_rd_data_valid = br_rd_data_valid; the other client's rd_data_valid stays 0.
  - Count valid beats; on the BURST_COUNT-th beat return to IDLE in the same edge.
  - No timeout; RAM latency (e.g. 6 cycles) is absorbed.
- Outside READ_WAIT, br_rd_data_valid is ignored (never routed).
- br_cmd_en=0 in every state except ISSUE. br_wr_data/br_data_mask follow the owner mux in all states.
- Back-to-back: the earliest re-grant is 1 cycle after return to IDLE. Minimum spacing of two writes is BURST_COUNT+1 cycles from br_cmd_en to br_cmd_en.
- Fairness: with both clients requesting continuously, grants alternate 0,1,0,1.
- A req dropped before gnt is a withdrawal and is legal. Dropping req after gnt has no effect; the burst completes.
- A req from the owner during its own burst is not considered until IDLE.
- br_busy high in IDLE holds the arbiter in IDLE; br_busy is not sampled in other states.
- br_init_calib low blocks all grants.
- Reset mid-burst: all state clears immediately (asynchronous). The integrator must reset BurstRAM concurrently, and clients re-request afterwards.
- Beat counter width is $clog2(BURST_COUNT)+1 and never wraps within a burst.

Decomposition:
- Package burst_ram_pkg holds:
  - CMD_READ=1'b0 and CMD_WRITE=1'b1.
  - The state enum.
  - A client index typedef (1 bit).
- Sub-module rr_arbiter_2: combinational 2-way round-robin pick from req[1:0] and the last owner. Outputs are grant index and any_req.
- The FSM, latches and muxes live in burst_ram_arbiter.

Test Plan:
- Calibration gate: hold br_init_calib=0 for 10 cycles with c0_req=1. Expect no gnt. After calib=1 and busy=0, expect c0_gnt and br_cmd_en 1 cycle later with br_addr = c0_addr (0x010).
- Single write:
  - Stimulus: c1 writes addr 0x020 with beats 0x11..,0x22..,0x33..,0x44..
  - Expect br_wr_data to show the 4 beats on 4 consecutive cycles starting at br_cmd_en.
  - Read back through c0 returns the same 4 beats with c0_rd_data_valid only; c1_rd_data_valid stays 0.
- Tie after reset: both clients request reads simultaneously. Expect client 0 granted first and client 1 granted after 4 valid beats plus 1 cycle. owner ends at 1.
- Sustained contention: both clients issue 8 write bursts continuously. Expect a strict 0,1,0,1 grant sequence and br_cmd_en spacing of 5 cycles.
- Stray valid and busy:
  - Inject br_rd_data_valid in IDLE: expect neither rd_data_valid to assert.
  - Hold br_busy=1 with req high: expect no br_cmd_en until br_busy falls.
- Reset mid-read: assert sys_rst_n=0 after 2 of 4 beats. Expect immediate state=IDLE, busy=0, owner=1, all outputs 0. After release, a new c1 read completes normally.
